frame_load_arbiter: RTL
=======================

# frame_load_arbiter

Round-robin controller that shares the 4-stage, 32-bit word shift chain (delay line with per-stage parallel taps) between several word-stream requesters. It grants the chain to one requester at a time, gates exactly DEPTH word shifts from that requester into the chain, then freezes the chain and presents a frame-valid handshake so the downstream consumer can sample the parallel taps. It sits between the requester ports and the shift chain's data and shift-enable inputs.

## Interface
- W, 32, word width (matches the chain width).
- NREQ, 4, number of requesters, 2..16, not required to be a power of two.
- DEPTH, 4, words per frame; must equal the chain stage count (n+1); range 2..16.
- OW, $clog2(NREQ), owner-id width (derived, not overridable).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester word valid.
- req_data  in  NREQ*W  per-requester word; requester k occupies bits [k*W +: W].
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- shift_en  out  1  chain shift strobe; chain captures shift_data on this edge.
- shift_data  out  W  word into chain stage 0.
- frame_valid  out  1  chain holds a complete frame from frame_owner.
- frame_owner  out  OW  index of the requester whose frame is in the chain.
- frame_ready  in  1  consumer has sampled the taps.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, SHIFT, HOLD. Registers: state, owner (OW), ptr (OW, round-robin start), cnt ($clog2(DEPTH)).
- IDLE: if any req_valid, select the first set bit scanning ptr, ptr+1, … modulo NREQ; register owner; cnt=0; go to SHIFT. No req_ready or shift_en in IDLE.
- SHIFT: req_ready[owner]=1 (combinational from state/owner); all other req_ready=0. Transfer = req_valid[owner] & req_ready[owner]. On transfer: shift_en=1 and shift_data=req_data[owner] in the same cycle; cnt increments. Transfer with cnt==DEPTH-1: go to HOLD, cnt=0.
- Owner dropping req_valid mid-frame stalls: shift_en=0, cnt held, no timeout. Other requesters' req_valid is ignored until the frame completes.
- HOLD: frame_valid=1, frame_owner=owner, shift_en=0 (taps stable), req_ready=0. When frame_ready=1: go to IDLE, ptr = (owner+1) mod NREQ (explicit wrap, not bit truncation).
- shift_data = 0 whenever shift_en=0.
- Word order: first accepted word ends in the deepest stage, last word in stage 0.

## Timing
- Reset values: state=IDLE, ptr=0, owner=0, cnt=0; req_ready=0, shift_en=0, shift_data=0, frame_valid=0, frame_owner=0, busy=0.
- Arbitration latency: one cycle (IDLE cycle); earliest first transfer is the cycle after req_valid is sampled in IDLE.
- frame_valid rises the cycle after the last transfer. Minimum frame period with continuous valid and frame_ready tied high: 1 + DEPTH + 1 cycles (6 at defaults).
- frame_ready sampled only in HOLD; frame_ready high in other states has no effect.
- Simultaneous requests: only the scan order from ptr decides; no fixed priority.
- Reset mid-frame (any state): immediate return to reset values; partial frame discarded, no frame_valid; the chain shares rst and is cleared too. After release, arbitration starts from ptr=0.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 before the next edge; busy=0.
- Single requester 1 with words 0xA0..0xA3, valid held, frame_ready=1 -> IDLE 1 cycle; shift_en high 4 consecutive cycles with shift_data 0xA0,0xA1,0xA2,0xA3; frame_valid for 1 cycle with frame_owner=1; next grant scan starts at 2.
- All 4 requesters continuously valid, frame_ready=1 -> owners 0,1,2,3,0 in order; one frame every 6 cycles; never two req_ready bits high.
- Stall: owner 2 drops req_valid for 3 cycles after 2 words -> shift_en low 3 cycles, cnt held; frame completes with 4 words total; frame_valid appears 3 cycles later than unstalled.
- Backpressure: frame_ready low 5 cycles in HOLD with other requesters valid -> frame_valid and frame_owner held, shift_en=0, all req_ready=0; IDLE follows the cycle after frame_ready=1.
- Abort: rst pulsed in SHIFT after 2 transfers from requester 3 -> no frame_valid; after release with requesters 1 and 3 valid, requester 1 wins (ptr=0).

Source files
------------

// File: rtl/frame_load_arbiter.sv
// Round-robin owner of the word shift chain: grants one requester, gates DEPTH
// shifts from it, then freezes the chain and holds frame_valid until consumed.
module frame_load_arbiter #(
  parameter int W     = 32,
  parameter int NREQ  = 4,
  parameter int DEPTH = 4,
  localparam int OW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              shift_en,
  output logic [W-1:0]      shift_data,
  output logic              frame_valid,
  output logic [OW-1:0]     frame_owner,
  input  logic              frame_ready,
  output logic              busy
);

  localparam int CW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t          state;
  logic [OW-1:0]   owner;
  logic [OW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [OW-1:0]   grant_idx;
  logic            grant_found;
  logic            xfer;

  // NREQ need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] v);
    return (v == OW'(NREQ - 1)) ? '0 : v + 1'b1;
  endfunction

  // Scan from ptr downward in reverse so the nearest offset overwrites last.
  always_comb begin
    int            j;
    logic [OW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    j           = 0;
    cand        = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      cand = OW'(j);
      if (req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign xfer        = (state == SHIFT) && req_valid[owner];
  assign req_ready   = (state == SHIFT) ? (NREQ'(1) << owner) : '0;
  assign shift_en    = xfer;
  assign shift_data  = xfer ? req_data[owner*W +: W] : '0;
  assign frame_valid = (state == HOLD);
  assign frame_owner = frame_valid ? owner : '0;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            owner <= grant_idx;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (xfer) begin
            if (cnt == CW'(DEPTH - 1)) begin
              cnt   <= '0;
              state <= HOLD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (frame_ready) begin
            ptr   <= wrap_inc(owner);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
